// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: opcodes, datapath
// select codes and the controller state type.
package main_fsm_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } fsm_state_t;

endpackage

// File: rtl/main_fsm_imm_src_decoder.sv
// Immediate-format select derived purely from the opcode; unknown opcodes
// fall back to the I-type format.
module imm_src_decoder
  import main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immsrc
);

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_LW, OP_I: immsrc = IMM_I;
      OP_SW:       immsrc = IMM_S;
      OP_BEQ:      immsrc = IMM_B;
      OP_JAL:      immsrc = IMM_J;
      default:     immsrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and counts retired instructions.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int INSTRET_W       = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 adrsrc,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 regwrite,
  output logic                 memwrite,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           resultsrc,
  output logic [1:0]           aluop,
  output logic [1:0]           immsrc,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  fsm_state_t state, state_nxt;
  logic       pcupdate;
  logic       branch;
  logic       retire;
  logic [1:0] immsrc_dec;

  imm_src_decoder u_imm_src_decoder (
    .op     (op),
    .immsrc (immsrc_dec)
  );

  // Held at zero in S_RESET so that every output is quiet during reset.
  assign immsrc  = (state == S_RESET) ? IMM_I : immsrc_dec;
  assign pcwrite = pcupdate | (branch & zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    adrsrc        = 1'b0;
    irwrite       = 1'b0;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    regwrite      = 1'b0;
    memwrite      = 1'b0;
    alusrca       = SRCA_PC;
    alusrcb       = SRCB_RS2;
    resultsrc     = RES_ALUOUT;
    aluop         = ALUOP_ADD;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        irwrite   = mem_ready;
        pcupdate  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is being decoded.
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_nxt = S_TRAP;
            end else begin
              state_nxt = S_FETCH;
              retire    = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_IMM;
        state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_MEM;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc = RES_ALUOUT;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // Jump via the precomputed target; ALU forms PC+4 for the link write.
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
        pcupdate  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_TRAP: illegal_instr = 1'b1;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + INSTRET_ONE;
  end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: instruction-level model expands each
// instruction into its expected per-cycle outputs for two DUT configurations.
module tb_main_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  // Index 1: TRAP_ON_ILLEGAL=1, 32-bit counter. Index 0: TRAP_ON_ILLEGAL=0, 3-bit counter.
  logic [1:0] mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;
  logic [1:0] alusrca [2];
  logic [1:0] alusrcb [2];
  logic [1:0] resultsrc [2];
  logic [1:0] aluop [2];
  logic [1:0] immsrc [2];
  logic [31:0] instret1;
  logic [2:0]  instret0;

  main_fsm #(.INSTRET_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req[1]), .adrsrc(adrsrc[1]), .irwrite(irwrite[1]),
    .pcwrite(pcwrite[1]), .regwrite(regwrite[1]), .memwrite(memwrite[1]),
    .alusrca(alusrca[1]), .alusrcb(alusrcb[1]), .resultsrc(resultsrc[1]),
    .aluop(aluop[1]), .immsrc(immsrc[1]), .illegal_instr(illegal[1]),
    .instret(instret1)
  );

  main_fsm #(.INSTRET_W(3), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req[0]), .adrsrc(adrsrc[0]), .irwrite(irwrite[0]),
    .pcwrite(pcwrite[0]), .regwrite(regwrite[0]), .memwrite(memwrite[0]),
    .alusrca(alusrca[0]), .alusrcb(alusrcb[0]), .resultsrc(resultsrc[0]),
    .aluop(aluop[0]), .immsrc(immsrc[0]), .illegal_instr(illegal[0]),
    .instret(instret0)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_low;
    logic [6:0]  op;
    bit          z;
    bit          mr;
    logic [16:0] e1;
    logic [16:0] e0;
    logic [31:0] i1;
    logic [31:0] i0;
    bit          lit;
    logic [16:0] lo;
    logic [31:0] lr;
  } cyc_t;

  cyc_t        tbl[$];
  logic [31:0] cnt1 = 0, cnt0 = 0;
  int          tests = 0, fails = 0;

  // Output vector: {mem_req,adrsrc,irwrite,pcwrite,regwrite,memwrite,
  //                 alusrca,alusrcb,resultsrc,aluop,immsrc,illegal_instr}
  function automatic logic [16:0] mk(input bit mreq, adr, irw, pcw, rw, mw,
                                     input logic [1:0] a, b, res, alu, imm,
                                     input bit ill);
    return {mreq, adr, irw, pcw, rw, mw, a, b, res, alu, imm, ill};
  endfunction

  function automatic logic [16:0] obs(input int k);
    return {mem_req[k], adrsrc[k], irwrite[k], pcwrite[k], regwrite[k], memwrite[k],
            alusrca[k], alusrcb[k], resultsrc[k], aluop[k], immsrc[k], illegal[k]};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      LW, IT:  return 2'b00;
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push(input bit rst_low, input logic [6:0] o, input bit z, mr,
                      input logic [16:0] e1, input bit r1,
                      input logic [16:0] e0, input bit r0);
    cyc_t c;
    if (rst_low) begin
      cnt1 = 0;
      cnt0 = 0;
    end
    c.rst_low = rst_low; c.op = o; c.z = z; c.mr = mr;
    c.e1 = e1; c.e0 = e0;
    c.i1 = cnt1; c.i0 = cnt0 & 32'd7;
    c.lit = 1'b0; c.lo = '0; c.lr = '0;
    cnt1 = cnt1 + 32'(r1);
    cnt0 = cnt0 + 32'(r0);
    tbl.push_back(c);
  endtask

  task automatic same(input bit rst_low, input logic [6:0] o, input bit z, mr,
                      input logic [16:0] e, input bit r);
    push(rst_low, o, z, mr, e, r, e, r);
  endtask

  task automatic set_lit(input int i, input logic [16:0] lo, input logic [31:0] lr);
    cyc_t c;
    c = tbl[i];
    c.lit = 1'b1; c.lo = lo; c.lr = lr;
    tbl[i] = c;
  endtask

  task automatic do_reset(input logic [6:0] o);
    same(1, o, 0, 0, '0, 0);
    same(1, o, 0, 1, '0, 0);
    same(0, o, 0, 1, '0, 0);
  endtask

  function automatic logic [16:0] fetch_o(input logic [6:0] o, input bit mr);
    return mk(1, 0, mr, mr, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, imm_of(o), 0);
  endfunction

  function automatic logic [16:0] decode_o(input logic [6:0] o);
    return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, imm_of(o), 0);
  endfunction

  // One instruction: fw fetch wait cycles, mw memory wait cycles; z drives the
  // zero flag throughout, idle_mr drives mem_ready in non-memory states.
  task automatic instr(input logic [6:0] o, input int fw, mw, input bit z, idle_mr);
    logic [1:0] im;
    im = imm_of(o);
    for (int k = 0; k < fw; k++) same(0, o, z, 0, fetch_o(o, 0), 0);
    same(0, o, z, 1, fetch_o(o, 1), 0);
    same(0, o, z, idle_mr, decode_o(o), 0);
    case (o)
      LW: begin
        same(0, o, z, idle_mr, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, im, 0), 0);
        for (int k = 0; k < mw; k++)
          same(0, o, z, 0, mk(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, im, 0), 0);
        same(0, o, z, 1, mk(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, im, 0), 0);
        same(0, o, z, idle_mr, mk(0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, im, 0), 1);
      end
      SW: begin
        same(0, o, z, idle_mr, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, im, 0), 0);
        for (int k = 0; k < mw; k++)
          same(0, o, z, 0, mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, im, 0), 0);
        same(0, o, z, 1, mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, im, 0), 1);
      end
      RT, IT: begin
        same(0, o, z, idle_mr,
             mk(0,0,0,0,0,0, 2'b10, (o == RT) ? 2'b00 : 2'b01, 2'b00, 2'b10, im, 0), 0);
        same(0, o, z, idle_mr, mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, im, 0), 1);
      end
      BQ: same(0, o, z, idle_mr, mk(0,0,0,z,0,0, 2'b10,2'b00,2'b00,2'b01, im, 0), 1);
      JL: begin
        same(0, o, z, idle_mr, mk(0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, im, 0), 0);
        same(0, o, z, idle_mr, mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, im, 0), 1);
      end
      default: ;
    endcase
  endtask

  task automatic check(input string nm, input int cyc, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    int idx;
    do_reset(7'd0);

    idx = tbl.size();
    instr(RT, 0, 0, 0, 1);
    set_lit(idx + 2, 17'b000000_10_00_00_10_00_0, 32'd0);
    instr(LW, 0, 2, 1, 0);
    idx = tbl.size();
    instr(SW, 1, 1, 0, 1);
    set_lit(idx, 17'b100000_00_10_10_00_01_0, 32'd2);
    instr(IT, 0, 0, 1, 0);
    instr(BQ, 0, 0, 1, 1);
    instr(BQ, 0, 0, 0, 0);
    idx = tbl.size();
    instr(JL, 0, 0, 0, 1);
    set_lit(idx + 2, 17'b000100_01_10_00_00_11_0, 32'd6);

    // Illegal opcode: trapping instance locks up, the other retires it as a
    // NOP and keeps cycling through FETCH/DECODE (wrapping its 3-bit counter).
    same(0, BAD, 0, 1, fetch_o(BAD, 1), 0);
    push(0, BAD, 0, 1, decode_o(BAD), 0, decode_o(BAD), 1);
    for (int k = 0; k < 20; k++) begin
      push(0, BAD, 0, 1, mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00, 1), 0,
           (k % 2 == 0) ? fetch_o(BAD, 1) : decode_o(BAD), k % 2);
      if (k == 10) set_lit(tbl.size() - 1, 17'b000000_00_00_00_00_00_1, 32'd7);
    end
    do_reset(BAD);

    // Reset in the middle of a stalled store.
    instr(RT, 0, 0, 1, 1);
    same(0, SW, 0, 1, fetch_o(SW, 1), 0);
    same(0, SW, 0, 0, decode_o(SW), 0);
    same(0, SW, 0, 0, mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b01, 0), 0);
    same(0, SW, 0, 0, mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0), 0);
    same(0, SW, 0, 0, mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b01, 0), 0);
    idx = tbl.size();
    do_reset(SW);
    set_lit(idx, 17'd0, 32'd0);
    instr(IT, 0, 0, 0, 1);
    same(0, RT, 0, 0, fetch_o(RT, 0), 0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n     = !tbl[i].rst_low;
      op        = tbl[i].op;
      zero      = tbl[i].z;
      mem_ready = tbl[i].mr;
      @(negedge clk);
      check("outputs_trap",  i, {15'd0, obs(1)}, {15'd0, tbl[i].e1});
      check("instret_trap",  i, instret1, tbl[i].i1);
      check("outputs_nop",   i, {15'd0, obs(0)}, {15'd0, tbl[i].e0});
      check("instret_nop",   i, {29'd0, instret0}, tbl[i].i0);
      if (tbl[i].lit) begin
        check("literal_outputs", i, {15'd0, obs(1)}, {15'd0, tbl[i].lo});
        check("literal_instret", i, instret1, tbl[i].lr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
